// File: rtl/pointwise_ctrl_pkg.sv
// Shared types for the pointwise pipeline schedule controllers.
package pointwise_ctrl_pkg;

  localparam int CTRL_CW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // [0] root (always 0), [1] x, [2] y
  typedef logic [2:0][CTRL_CW-1:0] ctrl_vars_t;

endpackage

// File: rtl/affine_loop_counter.sv
// Single wrapping loop counter: counts 0..max, wraps to 0 on the increment after max.
module affine_loop_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] val,
  output logic          wrap
);

  // wrap flags that the current value is the last of the loop
  assign wrap = (val == max);

  // counter register; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= wrap ? '0 : val + CW'(1);
    end
  end

endmodule

// File: rtl/pointwise_loop_controller.sv
// Schedule controller for one op port: walks the x/y iteration domain and issues
// a one-cycle strobe plus loop variables per iteration, with a start offset and II.
//
// state | meaning
// IDLE  | waiting for start
// DELAY | counting START_DELAY idle cycles
// RUN   | issuing iterations, one every II cycles
// DONE  | one-cycle done pulse, then back to IDLE
module pointwise_loop_controller
  import pointwise_ctrl_pkg::*;
#(
  parameter int CW          = 16,
  parameter int EXTENT_X    = 64,
  parameter int EXTENT_Y    = 64,
  parameter int START_DELAY = 0,
  parameter int II          = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                start,
  output logic                en,
  output logic [2:0][CW-1:0]  ctrl_vars,
  output logic                busy,
  output logic                done
);

  localparam logic [CW-1:0] MAX_X     = CW'(EXTENT_X - 1);
  localparam logic [CW-1:0] MAX_Y     = CW'(EXTENT_Y - 1);
  localparam logic [31:0]   DLY_TC    = 32'(START_DELAY - 1);
  localparam logic [31:0]   II_RELOAD = 32'(II - 1);

  ctrl_state_t state_q, state_d;
  logic [31:0] dly_cnt, ii_cnt;
  logic        last_q;
  logic        accept, issue, clr_cnt;
  logic [CW-1:0] x_val, y_val;
  logic        x_wrap, y_wrap;
  logic        en_d, busy_d, done_d;
  logic [2:0][CW-1:0] vars_d;

  assign accept  = (state_q == IDLE) && start && !flush;
  // an iteration goes out when the II spacer has expired and the sweep is not finished
  assign issue   = (state_q == RUN) && !last_q && (ii_cnt == '0) && !flush;
  assign clr_cnt = flush || accept;

  affine_loop_counter #(.CW(CW)) u_x_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (issue),
    .max  (MAX_X),
    .val  (x_val),
    .wrap (x_wrap)
  );

  affine_loop_counter #(.CW(CW)) u_y_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (issue && x_wrap),
    .max  (MAX_Y),
    .val  (y_val),
    .wrap (y_wrap)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (START_DELAY > 0) ? DELAY : RUN;
        DELAY:   if (dly_cnt == DLY_TC) state_d = RUN;
        // leave RUN one full II after the final strobe, so done keeps the strobe pitch
        RUN:     if (last_q && (ii_cnt == '0)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // next output values, registered below so no input reaches an output combinationally
  always_comb begin
    en_d   = issue;
    busy_d = (state_d == DELAY) || (state_d == RUN);
    done_d = (state_d == DONE);
    vars_d = ctrl_vars;
    if (clr_cnt) begin
      vars_d = '0;
    end else if (issue) begin
      vars_d[0] = '0;
      vars_d[1] = x_val;
      vars_d[2] = y_val;
    end
  end

  // delay counter, II spacer and end-of-sweep flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
      ii_cnt  <= '0;
      last_q  <= 1'b0;
    end else if (clr_cnt) begin
      dly_cnt <= '0;
      ii_cnt  <= '0;
      last_q  <= 1'b0;
    end else begin
      dly_cnt <= (state_q == DELAY) ? dly_cnt + 32'd1 : '0;
      if (issue)                ii_cnt <= II_RELOAD;
      else if (ii_cnt != '0)    ii_cnt <= ii_cnt - 32'd1;
      if (issue && x_wrap && y_wrap) last_q <= 1'b1;
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ctrl_vars <= '0;
    end else begin
      en        <= en_d;
      busy      <= busy_d;
      done      <= done_d;
      ctrl_vars <= vars_d;
    end
  end

endmodule

// File: tb/tb_pointwise_loop_controller.sv
// Directed bench for pointwise_loop_controller: default sweep, skewed instance,
// flush, start re-pulses, async reset and start+flush collision.
module tb_pointwise_loop_controller;

  logic clk = 1'b0;
  logic rst_n, flush, start, flush2, start2;
  logic en, busy, done, en2, busy2, done2;
  logic [2:0][15:0] ctrl_vars, vars2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pointwise_loop_controller dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
    .en(en), .ctrl_vars(ctrl_vars), .busy(busy), .done(done)
  );

  pointwise_loop_controller #(
    .CW(16), .EXTENT_X(4), .EXTENT_Y(2), .START_DELAY(5), .II(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .start(start2),
    .en(en2), .ctrl_vars(vars2), .busy(busy2), .done(done2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ctrl_vars !== '0) begin
      errors++;
      $display("FAIL reset_state en=%b busy=%b done=%b vars=%h required 0/0/0/0", en, busy, done, ctrl_vars);
    end
    checks++;
    if (en2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || vars2 !== '0) begin
      errors++;
      $display("FAIL reset_state2 en=%b busy=%b done=%b vars=%h required 0/0/0/0", en2, busy2, done2, vars2);
    end
  endtask

  task automatic test_sweep(input bit repulse);
    int n, x, y, last, done_c, bad;
    bit got_done;
    logic [2:0][15:0] exp;
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL sweep_accept busy=%b en=%b required busy=1 en=0", busy, en);
    end
    n = 0; x = 0; y = 0; last = 0; done_c = 0; got_done = 0;
    for (int c = 1; c <= 4200 && !got_done; c++) begin
      tick;
      start = 1'b0;
      if (en === 1'b1) begin
        exp[0] = '0; exp[1] = 16'(x); exp[2] = 16'(y);
        checks++;
        if (ctrl_vars !== exp) begin
          errors++;
          $display("FAIL sweep_vars strobe %0d got %h required %h", n, ctrl_vars, exp);
        end
        checks++;
        if (c != n + 1) begin
          errors++;
          $display("FAIL sweep_timing strobe %0d at cycle %0d required %0d", n, c, n + 1);
        end
        if (n == 64) begin
          checks++;
          if (ctrl_vars[1] !== 16'd0 || ctrl_vars[2] !== 16'd1) begin
            errors++;
            $display("FAIL sweep_xwrap x=%0d y=%0d required x=0 y=1", ctrl_vars[1], ctrl_vars[2]);
          end
        end
        n++; last = c;
        if (x == 63) begin x = 0; y++; end else x++;
        if (repulse && n == 50) start = 1'b1;
      end
      if (done === 1'b1) begin
        got_done = 1; done_c = c;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL sweep_busy_at_done busy=%b required 0", busy);
        end
      end
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL sweep_done_timeout no done within budget, strobes=%0d", n);
    end
    checks++;
    if (n != 4096 || last != 4096) begin
      errors++;
      $display("FAIL sweep_count strobes=%0d last=%0d required 4096/4096", n, last);
    end
    checks++;
    if (done_c != last + 1) begin
      errors++;
      $display("FAIL sweep_done_cycle done at %0d required %0d", done_c, last + 1);
    end
    if (repulse) begin
      start = 1'b1; tick; start = 1'b0;
      bad = 0;
      repeat (8) begin
        tick;
        if (en !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL repulse_done second sweep started, bad cycles=%0d required 0", bad);
      end
    end else begin
      tick;
      exp[0] = '0; exp[1] = 16'd63; exp[2] = 16'd63;
      checks++;
      if (done !== 1'b0 || en !== 1'b0 || ctrl_vars !== exp) begin
        errors++;
        $display("FAIL sweep_hold done=%b en=%b vars=%h required 0/0/%h", done, en, ctrl_vars, exp);
      end
    end
  endtask

  task automatic test_skewed;
    int n, x, y, last, done_c;
    bit got_done;
    logic [2:0][15:0] exp;
    start2 = 1'b1; tick; start2 = 1'b0;
    n = 0; x = 0; y = 0; last = 0; done_c = 0; got_done = 0;
    for (int c = 1; c <= 60 && !got_done; c++) begin
      tick;
      if (c == 3) begin
        checks++;
        if (busy2 !== 1'b1 || en2 !== 1'b0) begin
          errors++;
          $display("FAIL skew_delay busy=%b en=%b required 1/0", busy2, en2);
        end
      end
      if (en2 === 1'b1) begin
        exp[0] = '0; exp[1] = 16'(x); exp[2] = 16'(y);
        checks++;
        if (vars2 !== exp) begin
          errors++;
          $display("FAIL skew_vars strobe %0d got %h required %h", n, vars2, exp);
        end
        checks++;
        if (c != 6 + 3 * n) begin
          errors++;
          $display("FAIL skew_timing strobe %0d at cycle %0d required %0d", n, c, 6 + 3 * n);
        end
        n++; last = c;
        if (x == 3) begin x = 0; y++; end else x++;
      end
      if (done2 === 1'b1) begin got_done = 1; done_c = c; end
    end
    checks++;
    if (!got_done || n != 8) begin
      errors++;
      $display("FAIL skew_count done=%0d strobes=%0d required 1/8", got_done, n);
    end
    checks++;
    if (done_c != last + 3) begin
      errors++;
      $display("FAIL skew_done_cycle done at %0d required %0d", done_c, last + 3);
    end
  endtask

  task automatic test_flush;
    int n, bad;
    logic [2:0][15:0] exp;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    for (int c = 1; c <= 300 && n < 100; c++) begin
      tick;
      if (en === 1'b1) n++;
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL flush_reach strobes=%0d required 100", n);
    end
    flush = 1'b1; tick; flush = 1'b0;
    checks++;
    if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ctrl_vars !== '0) begin
      errors++;
      $display("FAIL flush_clear en=%b busy=%b done=%b vars=%h required 0/0/0/0", en, busy, done, ctrl_vars);
    end
    bad = 0;
    repeat (5) begin
      tick;
      if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_idle bad cycles=%0d required 0", bad);
    end
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (en === 1'b1) begin
        exp[0] = '0; exp[1] = 16'(n); exp[2] = '0;
        checks++;
        if (ctrl_vars !== exp || c != n + 1) begin
          errors++;
          $display("FAIL flush_restart strobe %0d cycle %0d got %h required %h at %0d", n, c, ctrl_vars, exp, n + 1);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL flush_restart_count strobes=%0d required 10", n);
    end
    flush = 1'b1; tick; flush = 1'b0;
  endtask

  task automatic test_start_flush_idle;
    int bad;
    start = 1'b1; flush = 1'b1; tick; start = 1'b0; flush = 1'b0;
    bad = 0;
    repeat (10) begin
      tick;
      if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL start_flush_collision bad cycles=%0d required 0", bad);
    end
  endtask

  task automatic test_async_reset;
    int bad;
    start = 1'b1; tick; start = 1'b0;
    repeat (20) tick;
    checks++;
    if (busy !== 1'b1 || en !== 1'b1 || ctrl_vars[1] !== 16'd19) begin
      errors++;
      $display("FAIL areset_pre busy=%b en=%b x=%0d required 1/1/19", busy, en, ctrl_vars[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ctrl_vars !== '0) begin
      errors++;
      $display("FAIL areset_immediate en=%b busy=%b done=%b vars=%h required 0/0/0/0", en, busy, done, ctrl_vars);
    end
    tick; tick;
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick;
      if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL areset_idle bad cycles=%0d required 0", bad);
    end
    start = 1'b1; tick; start = 1'b0;
    tick;
    checks++;
    if (en !== 1'b1 || ctrl_vars !== '0) begin
      errors++;
      $display("FAIL areset_restart en=%b vars=%h required 1/0", en, ctrl_vars);
    end
    flush = 1'b1; tick; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; start2 = 1'b0; flush2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_sweep(1'b0);
    test_skewed;
    test_flush;
    test_sweep(1'b1);
    test_start_flush_idle;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
